lease_table_loader: RTL

- Upstream feeder for the lease policy controller's lease lookup table (LLT) and config register.
- Accepts a word stream (valid/ready) from the host/comm path and parses a header and a default lease.
- Emits registered write strobes into four LLT tables: address, lease0, lease1, lease0_prob.
- The cache holds off requests while busy_o is high.

---
 rtl/lease_table_loader.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/lease_table_loader.sv
// Stream loader for the lease lookup table (LLT) and config register.
// Optional trailer checksum check enabled by defining LEASE_LOADER_CHECKSUM_EN.
module lease_table_loader #(
   parameter int unsigned N_ENTRIES = 128,
   parameter int unsigned BW_DATA   = 32
) (
   input  logic                                 clock_i,
   input  logic                                 resetn_i,
   input  logic                                 start_i,
   input  logic                                 stream_valid_i,
   input  logic [BW_DATA-1:0]                   stream_data_i,
   output logic                                 stream_ready_o,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 error_o,
   output logic                                 con_wren_o,
   output logic                                 llt_wren_o,
   output logic [$clog2(N_ENTRIES)+1:0]         llt_addr_o,
   output logic [BW_DATA-1:0]                   llt_data_o
);

   localparam int unsigned BW_ENTRIES = $clog2(N_ENTRIES);
   localparam int unsigned BW_CNT     = BW_ENTRIES + 2;
   localparam logic [15:0] MAGIC      = 16'h1EA5;

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StHdr  = 3'd1;
   localparam logic [2:0] StDef  = 3'd2;
   localparam logic [2:0] StEnt  = 3'd3;
   localparam logic [2:0] StFin  = 3'd4;
   localparam logic [2:0] StChk  = 3'd5;

   logic [2:0]              state_q, state_d;
   logic [BW_ENTRIES:0]     n_q, n_d;
   logic [BW_ENTRIES-1:0]   idx_q, idx_d;
   logic [1:0]              tsel_q, tsel_d;
   logic [BW_CNT-1:0]       cnt_q, cnt_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic                    con_wren_q, con_wren_d;
   logic                    llt_wren_q, llt_wren_d;
   logic [BW_ENTRIES+1:0]   addr_q, addr_d;
   logic [BW_DATA-1:0]      data_q, data_d;

   logic                    accept;
   logic [15:0]             hdr_n;
   logic                    hdr_ok;
   logic [BW_ENTRIES:0]     n_m1;
   logic [BW_CNT:0]         words_m1;
   logic                    last_idx;
   logic                    last_word;
   logic [2:0]              after_entries;

`ifdef LEASE_LOADER_CHECKSUM_EN
   logic [BW_DATA-1:0]      csum_q, csum_d;
   assign after_entries  = StChk;
   assign stream_ready_o = (state_q == StHdr) || (state_q == StDef) || (state_q == StEnt) ||
                           (state_q == StChk);
`else
   assign after_entries  = StFin;
   assign stream_ready_o = (state_q == StHdr) || (state_q == StDef) || (state_q == StEnt);
`endif

   assign accept    = stream_valid_i & stream_ready_o;
   assign hdr_n     = stream_data_i[15:0];
   assign hdr_ok    = (stream_data_i[31:16] == MAGIC) && (hdr_n <= 16'(N_ENTRIES));
   assign n_m1      = n_q - (BW_ENTRIES+1)'(1);
   // Total entry words is 4*N; this is only consulted in StEnt where N >= 1.
   assign words_m1  = {n_q, 2'b00} - (BW_CNT+1)'(1);
   assign last_idx  = ({1'b0, idx_q} == n_m1);
   assign last_word = ({1'b0, cnt_q} == words_m1);

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      idx_d      = idx_q;
      tsel_d     = tsel_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = error_q;
      con_wren_d = 1'b0;
      llt_wren_d = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
`ifdef LEASE_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
      if (accept && (state_q != StChk)) begin
         csum_d = csum_q ^ stream_data_i;
      end
`endif
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StHdr;
               busy_d  = 1'b1;
               error_d = 1'b0;
               n_d     = '0;
               idx_d   = '0;
               tsel_d  = '0;
               cnt_d   = '0;
`ifdef LEASE_LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         StHdr: begin
            if (accept) begin
               if (hdr_ok) begin
                  n_d     = hdr_n[BW_ENTRIES:0];
                  state_d = StDef;
               end else begin
                  error_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end
            end
         end
         StDef: begin
            if (accept) begin
               con_wren_d = 1'b1;
               addr_d     = '0;
               data_d     = stream_data_i;
               state_d    = (n_q == '0) ? after_entries : StEnt;
            end
         end
         StEnt: begin
            if (accept) begin
               llt_wren_d = 1'b1;
               addr_d     = {tsel_q, idx_q};
               data_d     = stream_data_i;
               cnt_d      = cnt_q + BW_CNT'(1);
               if (last_idx) begin
                  idx_d  = '0;
                  tsel_d = tsel_q + 2'd1;
               end else begin
                  idx_d  = idx_q + BW_ENTRIES'(1);
               end
               if (last_word) begin
                  state_d = after_entries;
               end
            end
         end
`ifdef LEASE_LOADER_CHECKSUM_EN
         StChk: begin
            if (accept) begin
               if (stream_data_i == csum_q) begin
                  state_d = StFin;
               end else begin
                  error_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end
            end
         end
`endif
         StFin: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q    <= StIdle;
         n_q        <= '0;
         idx_q      <= '0;
         tsel_q     <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         con_wren_q <= 1'b0;
         llt_wren_q <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
`ifdef LEASE_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         idx_q      <= idx_d;
         tsel_q     <= tsel_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         con_wren_q <= con_wren_d;
         llt_wren_q <= llt_wren_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
`ifdef LEASE_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign error_o    = error_q;
   assign con_wren_o = con_wren_q;
   assign llt_wren_o = llt_wren_q;
   assign llt_addr_o = addr_q;
   assign llt_data_o = data_q;

endmodule
